// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter_if
// Purpose  : Bundles the fetch requester, data requester and external memory
//            bus signals of the memory bus arbiter.
// Modports : master - arbiter view (serves both requesters, drives the bus)
//            slave  - environment view (pipeline requesters + memory)
// Signals  : if_*    instruction fetch request/ack/data + flush
//            mem_*   data access request/ack/data, byte lanes
//            stallreq_if / stallreq_mem  pipeline stall requests
//            bus_*   registered single-ported memory bus, req/ack handshake
// Revision : 1.0 - initial release
// ============================================================================
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int SEL_W = DATA_W / 8;

    // Fetch requester
    logic              if_ce;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              flush;

    // Data requester
    logic              mem_ce;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [SEL_W-1:0]  mem_sel;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    // Pipeline stall requests
    logic              stallreq_if;
    logic              stallreq_mem;

    // External memory bus
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [SEL_W-1:0]  bus_sel;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;
    logic              bus_err;

    modport master (
        input  if_ce, if_addr, flush,
        input  mem_ce, mem_we, mem_addr, mem_sel, mem_wdata,
        input  bus_rdata, bus_ack,
        output if_ack, if_rdata,
        output mem_ack, mem_rdata,
        output stallreq_if, stallreq_mem,
        output bus_req, bus_we, bus_addr, bus_sel, bus_wdata, bus_err
    );

    modport slave (
        output if_ce, if_addr, flush,
        output mem_ce, mem_we, mem_addr, mem_sel, mem_wdata,
        output bus_rdata, bus_ack,
        input  if_ack, if_rdata,
        input  mem_ack, mem_rdata,
        input  stallreq_if, stallreq_mem,
        input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata, bus_err
    );

endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Shares one single-ported SRAM-like bus between instruction fetch
//            (read-only) and the data path (read/write with byte lanes).
//            Round-robin arbitration on ties, wait-state tolerant req/ack bus
//            handshake, fetch cancellation on flush, and a wait-cycle timeout
//            that completes the access with an error.
// Ports    : clk  - rising-edge clock
//            rst  - synchronous reset, active-low
//            bus  - mem_bus_arbiter_if.master (requesters, stalls, bus)
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mem_bus_arbiter_if.master bus
);

    localparam int         SEL_W       = DATA_W / 8;
    // Last wait count before the timeout fires: TIMEOUT bus_req cycles total.
    localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_IF_ACC     = 2'd1,
        S_MEM_ACC    = 2'd2,
        S_IF_DISCARD = 2'd3
    } state_t;

    state_t            r_state,     w_state_nxt;
    logic              r_last_mem,  w_last_mem_nxt;   // 1: last grant went to MEM
    logic [7:0]        r_wait,      w_wait_nxt;
    logic              r_bus_req,   w_bus_req_nxt;
    logic              r_bus_we,    w_bus_we_nxt;
    logic [ADDR_W-1:0] r_bus_addr,  w_bus_addr_nxt;
    logic [SEL_W-1:0]  r_bus_sel,   w_bus_sel_nxt;
    logic [DATA_W-1:0] r_bus_wdata, w_bus_wdata_nxt;
    logic              r_bus_err,   w_bus_err_nxt;
    logic              r_if_ack,    w_if_ack_nxt;
    logic              r_mem_ack,   w_mem_ack_nxt;
    logic [DATA_W-1:0] r_if_rdata,  w_if_rdata_nxt;
    logic [DATA_W-1:0] r_mem_rdata, w_mem_rdata_nxt;

    // A requester still holds ce in its ack cycle; that is not a new request.
    logic w_if_req;
    logic w_mem_req;
    logic w_grant_mem;
    logic w_done;
    logic w_timeout;

    assign w_if_req    = bus.if_ce  & ~r_if_ack;
    assign w_mem_req   = bus.mem_ce & ~r_mem_ack;
    assign w_grant_mem = w_mem_req & (~w_if_req | ~r_last_mem);
    assign w_done      = r_bus_req & bus.bus_ack;
    assign w_timeout   = r_bus_req & ~bus.bus_ack & (r_wait == c_WAIT_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_last_mem  <= 1'b0;
            r_wait      <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_sel   <= '0;
            r_bus_wdata <= '0;
            r_bus_err   <= 1'b0;
            r_if_ack    <= 1'b0;
            r_mem_ack   <= 1'b0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_last_mem  <= w_last_mem_nxt;
            r_wait      <= w_wait_nxt;
            r_bus_req   <= w_bus_req_nxt;
            r_bus_we    <= w_bus_we_nxt;
            r_bus_addr  <= w_bus_addr_nxt;
            r_bus_sel   <= w_bus_sel_nxt;
            r_bus_wdata <= w_bus_wdata_nxt;
            r_bus_err   <= w_bus_err_nxt;
            r_if_ack    <= w_if_ack_nxt;
            r_mem_ack   <= w_mem_ack_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_mem_rdata <= w_mem_rdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_last_mem_nxt  = r_last_mem;
        w_wait_nxt      = r_wait;
        w_bus_req_nxt   = r_bus_req;
        w_bus_we_nxt    = r_bus_we;
        w_bus_addr_nxt  = r_bus_addr;
        w_bus_sel_nxt   = r_bus_sel;
        w_bus_wdata_nxt = r_bus_wdata;
        w_bus_err_nxt   = 1'b0;
        w_if_ack_nxt    = 1'b0;
        w_mem_ack_nxt   = 1'b0;
        w_if_rdata_nxt  = r_if_rdata;
        w_mem_rdata_nxt = r_mem_rdata;

        case (r_state)
            S_IDLE: begin
                if (w_grant_mem) begin
                    w_state_nxt     = S_MEM_ACC;
                    w_last_mem_nxt  = 1'b1;
                    w_wait_nxt      = '0;
                    w_bus_req_nxt   = 1'b1;
                    w_bus_we_nxt    = bus.mem_we;
                    w_bus_addr_nxt  = bus.mem_addr;
                    w_bus_sel_nxt   = bus.mem_sel;
                    w_bus_wdata_nxt = bus.mem_wdata;
                end else if (w_if_req) begin
                    w_state_nxt     = S_IF_ACC;
                    w_last_mem_nxt  = 1'b0;
                    w_wait_nxt      = '0;
                    w_bus_req_nxt   = 1'b1;
                    w_bus_we_nxt    = 1'b0;
                    w_bus_addr_nxt  = bus.if_addr;
                    w_bus_sel_nxt   = '1;
                    w_bus_wdata_nxt = '0;
                end
            end

            S_IF_ACC: begin
                if (w_done || w_timeout) begin
                    w_state_nxt   = S_IDLE;
                    w_bus_req_nxt = 1'b0;
                    // A flush in the completion cycle still discards the fetch.
                    if (!bus.flush) begin
                        w_if_ack_nxt   = 1'b1;
                        w_bus_err_nxt  = w_timeout;
                        w_if_rdata_nxt = w_timeout ? '0 : bus.bus_rdata;
                    end
                end else begin
                    w_wait_nxt = r_wait + 8'd1;
                    if (bus.flush) begin
                        w_state_nxt = S_IF_DISCARD;
                    end
                end
            end

            S_MEM_ACC: begin
                if (w_done || w_timeout) begin
                    w_state_nxt     = S_IDLE;
                    w_bus_req_nxt   = 1'b0;
                    w_mem_ack_nxt   = 1'b1;
                    w_bus_err_nxt   = w_timeout;
                    w_mem_rdata_nxt = w_timeout ? '0 : bus.bus_rdata;
                end else begin
                    w_wait_nxt = r_wait + 8'd1;
                end
            end

            S_IF_DISCARD: begin
                // The bus cycle must still finish; its result is dropped silently.
                if (w_done || w_timeout) begin
                    w_state_nxt   = S_IDLE;
                    w_bus_req_nxt = 1'b0;
                end else begin
                    w_wait_nxt = r_wait + 8'd1;
                end
            end

            default: begin
                w_state_nxt   = S_IDLE;
                w_bus_req_nxt = 1'b0;
            end
        endcase
    end

    assign bus.if_ack       = r_if_ack;
    assign bus.if_rdata     = r_if_rdata;
    assign bus.mem_ack      = r_mem_ack;
    assign bus.mem_rdata    = r_mem_rdata;
    assign bus.stallreq_if  = bus.if_ce  & ~r_if_ack;
    assign bus.stallreq_mem = bus.mem_ce & ~r_mem_ack;
    assign bus.bus_req      = r_bus_req;
    assign bus.bus_we       = r_bus_we;
    assign bus.bus_addr     = r_bus_addr;
    assign bus.bus_sel      = r_bus_sel;
    assign bus.bus_wdata    = r_bus_wdata;
    assign bus.bus_err      = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Directed self-checking bench for mem_bus_arbiter. One instance
//            uses the default timeout, a second uses TIMEOUT=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif  ();
    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif2 ();

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.master)
    );

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut_to (
        .clk (clk),
        .rst (rst),
        .bus (bif2.master)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Step to just after the next rising edge; inputs are driven here.
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs follow freshly driven inputs before sampling.
    task automatic settle;
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    int req_cnt;
    int iack_cnt;
    int mack_cnt;
    int n_addr;
    logic [31:0] addrs [16];
    logic prev_req;
    logic done;

    initial begin
        bif.if_ce = 0;  bif.if_addr = 0;  bif.flush = 0;
        bif.mem_ce = 0; bif.mem_we = 0;   bif.mem_addr = 0; bif.mem_sel = 0; bif.mem_wdata = 0;
        bif.bus_rdata = 0; bif.bus_ack = 0;
        bif2.if_ce = 0;  bif2.if_addr = 0;  bif2.flush = 0;
        bif2.mem_ce = 0; bif2.mem_we = 0;   bif2.mem_addr = 0; bif2.mem_sel = 0; bif2.mem_wdata = 0;
        bif2.bus_rdata = 0; bif2.bus_ack = 0;

        // ---------------- reset state ----------------
        rst = 1'b0;
        cyc();
        cyc();
        settle();
        check("rst bus_req",  64'(bif.bus_req),  64'd0);
        check("rst bus_addr", 64'(bif.bus_addr), 64'd0);
        check("rst if_ack",   64'(bif.if_ack),   64'd0);
        check("rst mem_ack",  64'(bif.mem_ack),  64'd0);
        check("rst bus_err",  64'(bif.bus_err),  64'd0);
        check("rst if_rdata", 64'(bif.if_rdata), 64'd0);
        rst = 1'b1;

        // ---------------- single fetch, zero wait ----------------
        cyc();
        bif.if_ce = 1; bif.if_addr = 32'h0000_0100;
        settle();
        check("t1 c0 stallreq_if", 64'(bif.stallreq_if), 64'd1);
        check("t1 c0 bus_req",     64'(bif.bus_req),     64'd0);
        cyc();
        bif.bus_ack = 1; bif.bus_rdata = 32'h2402_0005;
        settle();
        check("t1 c1 bus_req",     64'(bif.bus_req),     64'd1);
        check("t1 c1 bus_addr",    64'(bif.bus_addr),    64'h100);
        check("t1 c1 bus_we",      64'(bif.bus_we),      64'd0);
        check("t1 c1 bus_sel",     64'(bif.bus_sel),     64'hF);
        check("t1 c1 stallreq_if", 64'(bif.stallreq_if), 64'd1);
        cyc();
        bif.bus_ack = 0;
        settle();
        check("t1 c2 bus_req",     64'(bif.bus_req),     64'd0);
        check("t1 c2 if_ack",      64'(bif.if_ack),      64'd1);
        check("t1 c2 if_rdata",    64'(bif.if_rdata),    64'h2402_0005);
        check("t1 c2 stallreq_if", 64'(bif.stallreq_if), 64'd0);
        cyc();
        bif.if_ce = 0;
        settle();
        check("t1 c3 if_ack",   64'(bif.if_ack),   64'd0);
        check("t1 c3 bus_req",  64'(bif.bus_req),  64'd0);
        check("t1 c3 if_rdata", 64'(bif.if_rdata), 64'h2402_0005);

        // ---------------- data write, 3 wait states ----------------
        req_cnt = 0; mack_cnt = 0; iack_cnt = 0; done = 0;
        for (int k = 0; k <= 8; k++) begin
            cyc();
            if (k == 0) begin
                bif.mem_ce = 1; bif.mem_we = 1; bif.mem_addr = 32'h8000_0010;
                bif.mem_sel = 4'b0011; bif.mem_wdata = 32'hDEAD_BEEF;
            end
            if (done) bif.mem_ce = 0;
            bif.bus_ack = (k == 4);
            settle();
            req_cnt  += int'(bif.bus_req);
            mack_cnt += int'(bif.mem_ack);
            iack_cnt += int'(bif.if_ack);
            if (k == 1) begin
                check("t2 bus_we",    64'(bif.bus_we),    64'd1);
                check("t2 bus_addr",  64'(bif.bus_addr),  64'h8000_0010);
                check("t2 bus_sel",   64'(bif.bus_sel),   64'h3);
                check("t2 bus_wdata", 64'(bif.bus_wdata), 64'hDEAD_BEEF);
            end
            if (k == 5) check("t2 mem_ack k5", 64'(bif.mem_ack), 64'd1);
            if (bif.mem_ack) done = 1;
        end
        check("t2 bus_req cycles", 64'(req_cnt),  64'd4);
        check("t2 mem_ack count",  64'(mack_cnt), 64'd1);
        check("t2 if_ack count",   64'(iack_cnt), 64'd0);
        bif.mem_ce = 0; bif.mem_we = 0;

        // ---------------- round-robin with both held ----------------
        do_reset();
        bif.mem_ce = 1; bif.mem_we = 0; bif.mem_addr = 32'h8000_0020; bif.mem_sel = 4'hF;
        bif.if_ce = 1;  bif.if_addr = 32'h0000_0200;
        n_addr = 0; prev_req = 0;
        for (int k = 0; k <= 13; k++) begin
            cyc();
            bif.bus_ack   = bif.bus_req;
            bif.bus_rdata = 32'h1000 + 32'(k);
            settle();
            if (bif.bus_req && !prev_req && n_addr < 16) begin
                addrs[n_addr] = bif.bus_addr;
                n_addr++;
            end
            prev_req = bif.bus_req;
        end
        check("t3 grant count", 64'(n_addr >= 4), 64'd1);
        check("t3 grant0 MEM",  64'(addrs[0]), 64'h8000_0020);
        check("t3 grant1 IF",   64'(addrs[1]), 64'h0000_0200);
        check("t3 grant2 MEM",  64'(addrs[2]), 64'h8000_0020);
        check("t3 grant3 IF",   64'(addrs[3]), 64'h0000_0200);
        bif.mem_ce = 0; bif.if_ce = 0; bif.bus_ack = 0;
        do_reset();

        // ---------------- flush during fetch, 5 wait states ----------------
        req_cnt = 0; iack_cnt = 0; done = 0;
        for (int k = 0; k <= 12; k++) begin
            cyc();
            bif.if_addr   = (k >= 8) ? 32'h0000_0400 : 32'h0000_0300;
            bif.if_ce     = (k <= 2) || (k >= 8 && !done);
            bif.flush     = (k == 2);
            bif.bus_ack   = (k == 6) || (k == 9);
            bif.bus_rdata = (k == 6) ? 32'hAAAA_0300 : 32'hBBBB_0400;
            settle();
            if (k <= 7) req_cnt  += int'(bif.bus_req);
            if (k <= 8) iack_cnt += int'(bif.if_ack);
            if (k == 9) begin
                check("t4 refetch bus_req",  64'(bif.bus_req),  64'd1);
                check("t4 refetch bus_addr", 64'(bif.bus_addr), 64'h400);
            end
            if (k == 10) begin
                check("t4 refetch if_ack",   64'(bif.if_ack),   64'd1);
                check("t4 refetch if_rdata", 64'(bif.if_rdata), 64'hBBBB_0400);
            end
            if (bif.if_ack) done = 1;
        end
        check("t4 discard bus_req cycles", 64'(req_cnt),  64'd6);
        check("t4 discard if_ack count",   64'(iack_cnt), 64'd0);
        bif.if_ce = 0; bif.flush = 0; bif.bus_ack = 0;

        // ---------------- reset at wait cycle 1 of a MEM access ----------------
        cyc();
        bif.mem_ce = 1; bif.mem_we = 0; bif.mem_addr = 32'h8000_0040; bif.mem_sel = 4'hF;
        cyc();
        settle();
        check("t6 bus_req before rst", 64'(bif.bus_req), 64'd1);
        rst = 1'b0;
        cyc();
        settle();
        check("t6 rst bus_req",  64'(bif.bus_req),  64'd0);
        check("t6 rst bus_addr", 64'(bif.bus_addr), 64'd0);
        check("t6 rst bus_sel",  64'(bif.bus_sel),  64'd0);
        check("t6 rst if_rdata", 64'(bif.if_rdata), 64'd0);
        check("t6 rst mem_ack",  64'(bif.mem_ack),  64'd0);
        rst = 1'b1;
        bif.mem_ce = 0;
        req_cnt = 0; mack_cnt = 0;
        for (int k = 0; k <= 5; k++) begin
            cyc();
            bif.bus_ack = k[0];
            settle();
            req_cnt  += int'(bif.bus_req);
            mack_cnt += int'(bif.mem_ack);
        end
        check("t6 post-rst bus_req cycles", 64'(req_cnt),  64'd0);
        check("t6 post-rst mem_ack count",  64'(mack_cnt), 64'd0);
        bif.bus_ack = 0;

        // ---------------- timeout, TIMEOUT=4 ----------------
        req_cnt = 0; done = 0;
        for (int k = 0; k <= 12; k++) begin
            cyc();
            bif2.mem_ce    = (k <= 2) || (k >= 4 && !done);
            bif2.mem_we    = 0;
            bif2.mem_sel   = 4'hF;
            bif2.mem_addr  = (k >= 4) ? 32'h0000_0020 : 32'h0000_0010;
            bif2.bus_ack   = (k == 1);
            bif2.bus_rdata = 32'h1234_5678;
            settle();
            if (k == 2) begin
                check("t5 pre mem_ack",   64'(bif2.mem_ack),   64'd1);
                check("t5 pre mem_rdata", 64'(bif2.mem_rdata), 64'h1234_5678);
                check("t5 pre bus_err",   64'(bif2.bus_err),   64'd0);
            end
            if (k >= 5) req_cnt += int'(bif2.bus_req);
            if (k == 9) begin
                check("t5 to mem_ack",   64'(bif2.mem_ack),   64'd1);
                check("t5 to bus_err",   64'(bif2.bus_err),   64'd1);
                check("t5 to mem_rdata", 64'(bif2.mem_rdata), 64'd0);
            end
            if (k == 10) check("t5 bus_err pulse", 64'(bif2.bus_err), 64'd0);
            if (k >= 5 && bif2.mem_ack) done = 1;
        end
        check("t5 bus_req cycles", 64'(req_cnt), 64'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares one single-ported memory bus between two requesters: instruction fetch (read-only) and the data-access path at the memory stage (read/write, byte lanes). The bus side uses a req/ack handshake with an arbitrary number of wait states. Each requester gets a one-cycle ack with read data, plus a stall request held until its access completes. The block sits between the IF/MEM pipeline stages and the external SRAM-like bus, and feeds the pipeline controller's stall inputs.

Parameters:
ADDR_W, 32, address width of both requesters and the bus
DATA_W, 32, data width; byte-select width is DATA_W/8
TIMEOUT, 255, maximum bus wait cycles before an access is aborted with error (1..255)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-low
if_ce  input  1  fetch request; held with if_addr until if_ack
if_addr  input  ADDR_W  fetch address
if_ack  output  1  one-cycle pulse: fetch complete
if_rdata  output  DATA_W  fetch data, valid with if_ack
flush  input  1  pipeline flush; cancels an in-flight fetch
mem_ce  input  1  data request; held with all mem_* fields until mem_ack
mem_we  input  1  1 = write, 0 = read
mem_addr  input  ADDR_W  data address
mem_sel  input  DATA_W/8  byte lane enables
mem_wdata  input  DATA_W  write data
mem_ack  output  1  one-cycle pulse: data access complete
mem_rdata  output  DATA_W  read data, valid with mem_ack
stallreq_if  output  1  if_ce & ~if_ack (combinational)
stallreq_mem  output  1  mem_ce & ~mem_ack (combinational)
bus_req  output  1  registered bus request
bus_we  output  1  registered bus write enable
bus_addr  output  ADDR_W  registered bus address
bus_sel  output  DATA_W/8  registered byte selects
bus_wdata  output  DATA_W  registered write data
bus_rdata  input  DATA_W  bus read data, valid with bus_ack
bus_ack  input  1  bus completion; sampled only while bus_req=1
bus_err  output  1  one-cycle pulse alongside if_ack/mem_ack when the access timed out

Behaviour:
- Reset (rst=0 at an edge): state IDLE, last_grant=IF, wait counter 0. All registered outputs 0: bus_req, bus_we, bus_addr, bus_sel, bus_wdata, if_ack, mem_ack, if_rdata, mem_rdata, bus_err. Reset mid-access drops bus_req on that edge; the access is abandoned with no ack.
- States: IDLE, IF_ACC, MEM_ACC, IF_DISCARD.
- IDLE arbitration:
  - Only mem_ce: grant MEM.
  - Only if_ce: grant IF.
  - Both: grant the requester not equal to last_grant (round-robin). MEM therefore wins the first tie after reset.
  - Requests whose ack is high this cycle are ignored.
  - On grant: latch the bus fields, set bus_req=1 next cycle, set last_grant, clear the wait counter. IF with bus_we=0 and bus_sel all ones.
- IF_ACC / MEM_ACC:
  - On bus_ack: next edge deasserts bus_req, pulses the requester's ack, registers bus_rdata into its rdata, returns to IDLE.
  - Latency, measured from the cycle the request is first seen in IDLE: bus_req at +1. If bus_ack arrives at +1 (zero wait), ack at +2 and the earliest next bus_req at +3.
- Flush:
  - flush=1 in IF_ACC goes to IF_DISCARD. bus_req stays high until bus_ack; completion generates no if_ack; then IDLE.
  - flush in IDLE or MEM_ACC has no effect. Data accesses are never cancelled.
  - flush together with bus_ack in IF_ACC: the result is discarded (no if_ack).
- Timeout:
  - The wait counter increments each cycle bus_req=1 and bus_ack=0.
  - On reaching TIMEOUT: drop bus_req, pulse the owner's ack with bus_err=1 and rdata=0, return to IDLE.
  - A timed-out discard produces no ack and no error.
- if_rdata and mem_rdata hold their value between acks.
- bus_ack while bus_req=0 is ignored.

Test Plan:
- Single fetch, 0 wait states: if_ce=1, if_addr=0x0000_0100 at cycle 0; bus_ack at cycle 1 with rdata 0x2402_0005 -> bus_req high only in cycle 1; if_ack with if_rdata=0x2402_0005 at cycle 2; stallreq_if high in cycles 0-1.
- Data write, 3 wait states: mem_we=1, addr 0x8000_0010, sel 0b0011, wdata 0xDEAD_BEEF -> bus fields match; bus_req high for 4 cycles; one mem_ack; if_ack never pulses.
- Simultaneous requests after reset, both held: MEM is granted first, then IF, then MEM. Bus address sequence alternates mem_addr/if_addr with no back-to-back grant to the same requester.
- Flush during fetch with 5 wait states, flush pulsed at wait cycle 2 -> bus_req stays until bus_ack; no if_ack; next if_ce re-arbitrated from IDLE.
- Timeout with TIMEOUT=4, bus_ack held 0 -> bus_req high for exactly 4 cycles, then mem_ack=1, bus_err=1, mem_rdata=0.
- Reset asserted at wait cycle 1 of MEM access -> next edge: bus_req=0 and all outputs 0; no mem_ack after release until a new request.
